uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares the single UART transmitter between N_REQ requesters (result sender, debug/echo path, ...).
// - Each requester hands over one 32-bit word; the block serialises it MSB byte first on the UART byte interface.
// - Round-robin arbitration between requesters; a granted word is always sent to completion before the next grant.
// - Sits between the requesters and the UART TX core, which drives i_txd_busy.
// PARAMETERS
// - N_REQ        default 2   number of requesters, legal range 2..8
// - ACK_TIMEOUT  default 15  cycles to wait for i_txd_busy to rise after a strobe before re-strobing the same byte
// PORTS
// - i_Clk               in   1          system clock; every flop is on the rising edge
// - i_Rst               in   1          reset, asynchronous, active-high
// - i_req               in   N_REQ      level request per requester; held until its o_grant bit pulses
// - i_word              in   32*N_REQ   packed words; requester k uses bits [32k+31:32k]; must be valid while i_req[k]=1
// - i_txd_busy          in   1          UART busy; high while the UART is shifting a byte out
// - o_grant             out  N_REQ      one-hot 1-cycle pulse: word of that requester latched; requester may drop i_req
// - o_done              out  N_REQ      one-hot 1-cycle pulse: last byte of that requester's word finished on the line
// - o_tx_data           out  8          byte presented to the UART; stable from strobe until the byte completes
// - o_send_to_computer  out  1          1-cycle start strobe to the UART
// - o_active            out  1          high in any state except IDLE
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; byte index 0; timeout counter 0; RR pointer=N_REQ-1, so requester 0 wins first.
// - Reset mid-word: the word is abandoned; no o_done; nothing is resent after reset is released.
// - States: IDLE, SEND, WAIT_HI, WAIT_LO.
// - IDLE: if any i_req bit is high, select the first set bit scanning from RR pointer+1 upward, with wrap-around.
//   - On the next edge: latch its word, pulse its o_grant bit, update the RR pointer to the winner, set byte index 0, go to SEND.
// - SEND: wait for i_txd_busy=0.
//   - Then, for one cycle: drive the current byte on o_tx_data and o_send_to_computer=1.
//   - Clear the timeout counter and go to WAIT_HI.
// - WAIT_HI: if i_txd_busy=1, go to WAIT_LO.
//   - Otherwise increment the counter; when it reaches ACK_TIMEOUT, go to SEND to re-strobe the same byte, index unchanged.
// - WAIT_LO: when i_txd_busy=0:
//   - If the byte index is the last one: pulse the o_done bit of the owner and go to IDLE.
//   - Otherwise increment the index and go to SEND.
// - Byte order: index 0 sends word[31:24], 1 sends [23:16], 2 sends [15:8], 3 sends [7:0].
// - Minimum cost per byte: strobe 1 cycle, plus 1+ cycles in WAIT_HI, plus the busy time in WAIT_LO.
// - Back-to-back words: IDLE re-arbitrates in the cycle after o_done; no extra idle cycle is inserted.
// - Simultaneous requests: exactly one o_grant per word, strictly round-robin.
//   - With all requests held high, grant order is 0,1,..,N_REQ-1,0,...
// - A request that drops before its grant is ignored; no grant and no done for it.
// - i_req is not sampled for the current owner outside IDLE; a re-request re-enters arbitration at the next IDLE.
// - o_grant and o_done never both pulse in the same cycle.
// - i_txd_busy already high on entry to SEND: the strobe is held off until it falls.
// CONFIGURATION
// - TXARB_HEADER_EN defined: each word is preceded by a header byte 8'hA0 | owner index.
//   - Byte index 0 is the header; word bytes follow as indexes 1..4; last index is 4; 5 bytes per word.
// - TXARB_HEADER_EN undefined: no header; last index is 3; 4 bytes per word.
// TESTING
// - Reset with i_Rst pulse mid-word -> all outputs 0 immediately; no o_done for the abandoned word; next grant goes to requester 0.
// - i_req=2'b01, word0=32'hDEADBEEF, UART model busy 10 cycles -> strobes carry DE,AD,BE,EF in order; then o_done[0].
// - i_req=2'b11 held, word0=32'h11223344, word1=32'h55667788 -> grants 0,1,0,1; no byte interleaving between words.
// - UART model ignores the first strobe -> after 15 cycles the same byte is strobed again; the word still completes in order.
// - TXARB_HEADER_EN defined, requester 1, word 32'h01020304 -> bytes A1,01,02,03,04; then o_done[1].
// - i_req[1] pulsed for 1 cycle while requester 0 is sending -> no grant[1] and no done[1] for it.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises one 32-bit word per grant onto a shared UART byte port.
// Define TXARB_HEADER_EN to prefix each word with header byte 8'hA0 | owner index.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [32*N_REQ-1:0] i_word,
  input  logic               i_txd_busy,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_done,
  output logic [7:0]         o_tx_data,
  output logic               o_send_to_computer,
  output logic               o_active
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

`ifdef TXARB_HEADER_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] winner;
  logic [IW-1:0] scan_idx;
  logic          req_any;
  logic [31:0]   word_q;
  logic [2:0]    byte_idx;
  logic [CW-1:0] to_cnt;
  logic [7:0]    cur_byte;

  // Scan downward so the last hit is the nearest set bit after rr_ptr.
  always_comb begin
    winner   = '0;
    scan_idx = '0;
    req_any  = 1'b0;
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      scan_idx = IW'((32'(rr_ptr) + i) % N_REQ);
      if (i_req[scan_idx]) begin
        winner  = scan_idx;
        req_any = 1'b1;
      end
    end
  end

  always_comb begin
    cur_byte = '0;
`ifdef TXARB_HEADER_EN
    case (byte_idx)
      3'd0:    cur_byte = 8'hA0 | 8'(owner);
      3'd1:    cur_byte = word_q[31:24];
      3'd2:    cur_byte = word_q[23:16];
      3'd3:    cur_byte = word_q[15:8];
      3'd4:    cur_byte = word_q[7:0];
      default: cur_byte = '0;
    endcase
`else
    case (byte_idx)
      3'd0:    cur_byte = word_q[31:24];
      3'd1:    cur_byte = word_q[23:16];
      3'd2:    cur_byte = word_q[15:8];
      3'd3:    cur_byte = word_q[7:0];
      default: cur_byte = '0;
    endcase
`endif
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state              <= ST_IDLE;
      rr_ptr             <= IW'(N_REQ - 1);
      owner              <= '0;
      word_q             <= '0;
      byte_idx           <= '0;
      to_cnt             <= '0;
      o_grant            <= '0;
      o_done             <= '0;
      o_tx_data          <= '0;
      o_send_to_computer <= 1'b0;
    end else begin
      o_grant            <= '0;
      o_done             <= '0;
      o_send_to_computer <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            word_q   <= i_word[32*winner +: 32];
            o_grant  <= N_REQ'(1) << winner;
            rr_ptr   <= winner;
            owner    <= winner;
            byte_idx <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!i_txd_busy) begin
            o_tx_data          <= cur_byte;
            o_send_to_computer <= 1'b1;
            to_cnt             <= '0;
            state              <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (i_txd_busy) begin
            state <= ST_WAIT_LO;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == CW'(ACK_TIMEOUT - 1))
              state <= ST_SEND;
          end
        end
        ST_WAIT_LO: begin
          if (!i_txd_busy) begin
            if (byte_idx == LAST_IDX) begin
              o_done <= N_REQ'(1) << owner;
              state  <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_active = (state != ST_IDLE);

endmodule
